// File: rtl/adder_rr_ctrl_pkg.sv
// Shared types and defaults for the round-robin adder controller.
package adder_ctrl_pkg;

    localparam int BIT_WIDTH_DEF = 4;
    localparam int NUM_REQ_DEF   = 4;
    localparam int ID_W          = $clog2(NUM_REQ_DEF);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic                     ovf;
        logic [BIT_WIDTH_DEF-1:0] sum;
    } result_t;

endpackage

// File: rtl/adder_rr_ctrl_arb.sv
// Combinational round-robin arbiter: scans from rr_ptr+1 upward (mod NUM_REQ)
// and grants the first eligible requester.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner
);

    logic            found;
    logic [ID_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = idx;
            end
        end
    end

endmodule

// File: rtl/adder_rr_ctrl.sv
// Shares one registered adder between NUM_REQ requesters: round-robin issue,
// one op in flight, and a held result slot per requester.
module adder_rr_ctrl #(
    parameter  int BIT_WIDTH = adder_ctrl_pkg::BIT_WIDTH_DEF,
    parameter  int NUM_REQ   = adder_ctrl_pkg::NUM_REQ_DEF,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_cin,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [NUM_REQ*BIT_WIDTH-1:0] resp_sum,
    output logic [NUM_REQ-1:0]           resp_ovf,
    output logic [BIT_WIDTH-1:0]         add_a,
    output logic [BIT_WIDTH-1:0]         add_b,
    output logic                         add_cin,
    input  logic [BIT_WIDTH-1:0]         add_sum,
    input  logic                         add_ovf
);

    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [BIT_WIDTH-1:0] sum_q [NUM_REQ];
    logic [BIT_WIDTH-1:0] sum_d [NUM_REQ];
    logic [NUM_REQ-1:0]   ovf_q, ovf_d;
    logic                 inflight_q, inflight_d;
    logic [ID_W-1:0]      inflight_id_q, inflight_id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      winner;
    logic                 grant_any;

    // A requester with a held or in-flight result may not issue again; nothing issues in reset.
    always_comb begin
        eligible = req_valid & ~resp_valid_q;
        if (inflight_q) eligible[inflight_id_q] = 1'b0;
        if (!n_rst) eligible = '0;
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .winner   (winner)
    );

    assign grant_any = |grant;
    assign req_ready = grant;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant_any) begin
            add_a   = req_a[winner*BIT_WIDTH +: BIT_WIDTH];
            add_b   = req_b[winner*BIT_WIDTH +: BIT_WIDTH];
            add_cin = req_cin[winner];
        end
    end

    always_comb begin
        inflight_d    = grant_any;
        inflight_id_d = winner;
        rr_ptr_d      = grant_any ? winner : rr_ptr_q;
        resp_valid_d  = resp_valid_q & ~resp_ready;
        sum_d         = sum_q;
        ovf_d         = ovf_q;
        // Eligibility gating guarantees this slot is not being consumed at the same edge.
        if (inflight_q) begin
            resp_valid_d[inflight_id_q] = 1'b1;
            sum_d[inflight_id_q]        = add_sum;
            ovf_d[inflight_id_q]        = add_ovf;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the result slots are small and architecturally visible, so they are reset too.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            resp_valid_q  <= '0;
            sum_q         <= '{default: '0};
            ovf_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
        end else begin
            resp_valid_q  <= resp_valid_d;
            sum_q         <= sum_d;
            ovf_q         <= ovf_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    always_comb begin
        resp_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) resp_sum[i*BIT_WIDTH +: BIT_WIDTH] = sum_q[i];
    end

    assign resp_valid = resp_valid_q;
    assign resp_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_rr_ctrl.sv
// Self-checking bench for adder_rr_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the controller.
module tb_adder_rr_ctrl;
    import adder_ctrl_pkg::*;

    localparam int BW = BIT_WIDTH_DEF;
    localparam int N  = NUM_REQ_DEF;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [N-1:0]    req_valid, req_ready, req_cin;
    logic [N*BW-1:0] req_a, req_b;
    logic [N-1:0]    resp_valid, resp_ready, resp_ovf;
    logic [N*BW-1:0] resp_sum;
    logic [BW-1:0]   add_a, add_b, add_sum;
    logic            add_cin, add_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adder_rr_ctrl #(.BIT_WIDTH(BW), .NUM_REQ(N)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_ovf(resp_ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_ovf(add_ovf)
    );

    // Stand-in for the shared registered adder (no reset of its own).
    always @(posedge clk) begin
        {add_ovf, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {{BW{1'b0}}, add_cin};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-requester held results, one pending op, last winner.
    result_t m_res [N];
    bit      m_rv  [N];
    int      m_last;
    bit      m_infl;
    int      m_infl_id;
    result_t m_infl_res;
    int      last_gnt_cyc [N];
    int      cyc = 0;

    function automatic int model_pick();
        int idx;
        if (!n_rst) return -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (req_valid[idx] && !m_rv[idx] && !(m_infl && m_infl_id == idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_res[i]        = '0;
            m_rv[i]         = 1'b0;
            last_gnt_cyc[i] = -1;
        end
        m_last = N - 1;
        m_infl = 1'b0;
    endtask

    // Check the current cycle against the model, advance the model, step one edge.
    task automatic run_cycle();
        int          exp_w;
        int          v;
        int          g;
        logic [31:0] exp_rdy;
        #1;
        exp_w   = model_pick();
        exp_rdy = (exp_w >= 0) ? (32'd1 << exp_w) : 32'd0;
        check("req_ready", 32'(req_ready), exp_rdy);
        check("add_a",   32'(add_a),   (exp_w >= 0) ? 32'(req_a[exp_w*BW +: BW]) : 32'd0);
        check("add_b",   32'(add_b),   (exp_w >= 0) ? 32'(req_b[exp_w*BW +: BW]) : 32'd0);
        check("add_cin", 32'(add_cin), (exp_w >= 0) ? 32'(req_cin[exp_w]) : 32'd0);
        for (int i = 0; i < N; i++) begin
            check("resp_valid", 32'(resp_valid[i]), 32'(m_rv[i]));
            check("resp_sum",   32'(resp_sum[i*BW +: BW]), 32'(m_res[i].sum));
            check("resp_ovf",   32'(resp_ovf[i]), 32'(m_res[i].ovf));
        end
        g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) g = i;
        if (g >= 0) begin
            if (last_gnt_cyc[g] >= 0) check("grant_gap3", 32'(cyc - last_gnt_cyc[g] >= 3), 32'd1);
            last_gnt_cyc[g] = cyc;
        end

        if (!n_rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) if (m_rv[i] && resp_ready[i]) m_rv[i] = 1'b0;
            if (m_infl) begin
                m_rv[m_infl_id]  = 1'b1;
                m_res[m_infl_id] = m_infl_res;
            end
            m_infl = (exp_w >= 0);
            if (exp_w >= 0) begin
                v = int'(req_a[exp_w*BW +: BW]) + int'(req_b[exp_w*BW +: BW]) + int'(req_cin[exp_w]);
                m_infl_res.sum = v[BW-1:0];
                m_infl_res.ovf = v[BW];
                m_infl_id      = exp_w;
                m_last         = exp_w;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_op(input int id, input int a, input int b, input bit cin);
        req_a[id*BW +: BW] = BW'(a);
        req_b[id*BW +: BW] = BW'(b);
        req_cin[id]        = cin;
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        req_valid = '0;
        run_cycle();
        n_rst = 1'b1;
    endtask

    int order [5];

    initial begin
        n_rst      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = '1;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state: outputs quiet while n_rst is low.
        run_cycle();
        n_rst = 1'b1;

        // Single request from requester 2.
        set_op(2, 3, 5, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_add_a", 32'(add_a), 32'd3);
        check("single_add_b", 32'(add_b), 32'd5);
        run_cycle();
        req_valid = '0;
        run_cycle();
        check("single_rv", 32'(resp_valid[2]), 32'd1);
        check("single_sum", 32'(resp_sum[2*BW +: BW]), 32'd8);
        check("single_ovf", 32'(resp_ovf[2]), 32'd0);
        run_cycle();
        check("single_rv_clr", 32'(resp_valid[2]), 32'd0);

        // Overflow from requester 0.
        set_op(0, 15, 1, 1'b1);
        req_valid = 4'b0001;
        run_cycle();
        req_valid = '0;
        run_cycle();
        check("ovf1_sum", 32'(resp_sum[0 +: BW]), 32'd1);
        check("ovf1_ovf", 32'(resp_ovf[0]), 32'd1);
        run_cycle();
        set_op(0, 15, 15, 1'b1);
        req_valid = 4'b0001;
        run_cycle();
        req_valid = '0;
        run_cycle();
        check("ovf2_sum", 32'(resp_sum[0 +: BW]), 32'd15);
        check("ovf2_ovf", 32'(resp_ovf[0]), 32'd1);
        run_cycle();

        // Fairness: all requesters valid continuously after reset.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, i + 1, 2 * i, i[0]);
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            order[c] = -1;
            for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) order[c] = i;
            run_cycle();
        end
        check("fair_0", 32'(order[0]), 32'd0);
        check("fair_1", 32'(order[1]), 32'd1);
        check("fair_2", 32'(order[2]), 32'd2);
        check("fair_3", 32'(order[3]), 32'd3);
        check("fair_4", 32'(order[4]), 32'd0);
        req_valid = '0;
        for (int c = 0; c < 4; c++) run_cycle();

        // Backpressure on requester 1.
        do_reset();
        resp_ready = 4'b1101;
        set_op(1, 7, 2, 1'b0);
        set_op(3, 4, 4, 1'b0);
        req_valid = 4'b0010;
        run_cycle();
        req_valid = 4'b1010;
        run_cycle();
        #1;
        check("bp_ready1", 32'(req_ready[1]), 32'd0);
        check("bp_rv1", 32'(resp_valid[1]), 32'd1);
        check("bp_sum1", 32'(resp_sum[BW +: BW]), 32'd9);
        for (int c = 0; c < 4; c++) run_cycle();
        check("bp_hold", 32'(resp_sum[BW +: BW]), 32'd9);
        resp_ready = '1;
        req_valid  = 4'b0010;
        run_cycle();
        #1;
        check("bp_regrant", 32'(req_ready[1]), 32'd1);
        run_cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) run_cycle();

        // Reset in the cycle after a grant discards the in-flight op.
        do_reset();
        set_op(0, 6, 6, 1'b1);
        req_valid = 4'b0001;
        run_cycle();
        req_valid = '0;
        n_rst     = 1'b0;
        run_cycle();
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("rst_no_rv", 32'(resp_valid), 32'd0);
            check("rst_sum0", 32'(resp_sum[0 +: BW]), 32'd0);
            run_cycle();
        end
        set_op(1, 2, 2, 1'b0);
        req_valid = 4'b0011;
        #1;
        check("rst_prio0", 32'(req_ready), 32'h1);
        run_cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) run_cycle();

        // Idle stretch.
        for (int c = 0; c < 10; c++) begin
            check("idle_ready", 32'(req_ready), 32'd0);
            run_cycle();
        end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            n_rst      = ($urandom_range(0, 49) != 0);
            req_valid  = N'($urandom);
            resp_ready = N'($urandom) | N'($urandom);
            req_a      = (N*BW)'($urandom);
            req_b      = (N*BW)'($urandom);
            req_cin    = N'($urandom);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_rr_ctrl.md
Name: adder_rr_ctrl

Overview:
Round-robin controller that shares one registered N-bit adder (1-cycle latency, {overflow,sum} <= a+b+carry_in) between NUM_REQ requesters. Each requester uses a valid/ready request port and a valid/ready response port. The controller issues at most one operation per cycle into the adder. It tags each in-flight operation with the requester ID and holds each result in a per-requester result register until that requester consumes it. It sits between requester blocks and the shared adder_nbit instance.

Parameters:
BIT_WIDTH, 4, operand/sum width; must match the shared adder.
NUM_REQ, 4, number of requesters; 2..16.
ID_W, $clog2(NUM_REQ), requester index width (derived; not overridable).

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  request valid, one bit per requester
req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
req_a  in  NUM_REQ*BIT_WIDTH  operand A, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
req_b  in  NUM_REQ*BIT_WIDTH  operand B, same packing
req_cin  in  NUM_REQ  carry-in per requester
resp_valid  out  NUM_REQ  result available per requester
resp_ready  in  NUM_REQ  requester consumes result
resp_sum  out  NUM_REQ*BIT_WIDTH  result sum per requester, same packing
resp_ovf  out  NUM_REQ  carry-out per requester
add_a  out  BIT_WIDTH  to shared adder operand A
add_b  out  BIT_WIDTH  to shared adder operand B
add_cin  out  1  to shared adder carry_in
add_sum  in  BIT_WIDTH  from shared adder sum (valid 1 cycle after issue)
add_ovf  in  1  from shared adder overflow

Behaviour:
- Reset (n_rst low at a rising clk edge):
  - clears resp_valid, all result registers (sum=0, ovf=0) and the in-flight flag.
  - sets rr_ptr to NUM_REQ-1, so requester 0 has top priority after reset.
  - while n_rst is low, req_ready=0 and add_a/add_b/add_cin=0.
- Eligibility: requester i is eligible when req_valid[i] && !resp_valid[i] && !(inflight && inflight_id==i).
- Arbitration (combinational): the first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ wins.
  - req_ready[winner]=1, all other bits 0.
  - If no requester is eligible, req_ready=0 and the adder inputs are driven 0.
- Issue (cycle t): add_a/add_b/add_cin mux the winner's operands combinationally, and the adder registers them at the end-of-t edge. At that same edge:
  - inflight<=1, inflight_id<=winner, rr_ptr<=winner.
  - With no grant: inflight<=0 and rr_ptr holds.
- Capture (cycle t+1): add_sum/add_ovf are valid. At the end-of-t+1 edge, result[inflight_id]<={add_ovf,add_sum} and resp_valid[inflight_id]<=1.
- Latency: request handshake edge to resp_valid high = 1 clock edge later (resp_valid high from cycle t+2).
- Throughput: aggregate 1 op/cycle; per requester at most 1 op per 3 cycles (grant, in flight, consume).
- Response: resp_valid[i] holds, with stable resp_sum/resp_ovf, until resp_valid[i]&&resp_ready[i] at an edge, which clears it.
- Capture and consume to the same index at the same edge cannot occur, because of eligibility gating.
- A result held unconsumed blocks only its own requester; the others proceed.
- Arithmetic: no truncation. resp_ovf is the adder's carry-out (unsigned). Example with BIT_WIDTH=4: 15+15+1 gives sum=15, ovf=1.
- Requester operands are sampled only in the grant cycle; later changes have no effect.
- The shared adder's own reset is independent. The controller's reset discards any in-flight operation: its capture is suppressed and no resp_valid is raised.
- req_valid deasserted without a handshake is legal; no state is kept for un-granted requests.

Decomposition:
- Package adder_ctrl_pkg: BIT_WIDTH/NUM_REQ defaults, ID_W, typedef result_t = struct {logic ovf; logic [BIT_WIDTH-1:0] sum;}, typedef req_id_t.
- Sub-module rr_arbiter (NUM_REQ): eligible vector and rr_ptr in, one-hot grant and encoded winner out; purely combinational.
- The pointer register stays in adder_rr_ctrl.

Test Plan:
- Single request, BIT_WIDTH=4: req 2 sends a=3, b=5, cin=0 with resp_ready=1. Expect req_ready[2] in the same cycle, add_a=3/add_b=5 in that cycle, then resp_valid[2] two cycles later with sum=8, ovf=0, held one cycle.
- Overflow: req 0 sends a=15, b=1, cin=1. Expect resp sum=1, ovf=1. Then a=15, b=15, cin=1: expect sum=15, ovf=1.
- Fairness: after reset, all 4 requesters hold valid continuously with resp_ready=1.
  - Expect grants 0,1,2,3 in consecutive cycles, then 0 again.
  - resp_valid appears in the same order, one per cycle.
  - No requester is granted twice within any 3-cycle window.
- Backpressure: resp_ready[1]=0 after req 1 completes (a=7, b=2). Expect resp_valid[1]=1 with sum=9 held.
  - A new req_valid[1] gets req_ready[1]=0 while req 3 is still granted.
  - After resp_ready[1]=1 for one cycle, req 1 is granted the next cycle.
- Reset mid-operation: n_rst low in the cycle after req 0 is granted. Expect no resp_valid at any time and results zero.
  - After release, with req 1 and req 0 both valid, requester 0 is granted first.
- Idle: no req_valid for 10 cycles. Expect req_ready=0, add inputs 0, resp_valid unchanged, rr_ptr unchanged.
